// File: rtl/itch_msg_assembler_if.sv
// Byte-stream input and assembled-message output bundle of the ITCH message
// assembler. The stream source drives through the master modport; the
// assembler sits on the slave modport.
interface itch_msg_assembler_if #(
   parameter int REG_WIDTH     = 32,
   parameter int ERR_CNT_WIDTH = 16
);
   logic [7:0]               i_byte;
   logic                     i_byte_valid;
   logic                     i_byte_last;
   logic                     o_byte_ready;
   logic [REG_WIDTH-1:0]     o_reg_0;
   logic [REG_WIDTH-1:0]     o_reg_1;
   logic [REG_WIDTH-1:0]     o_reg_2;
   logic [REG_WIDTH-1:0]     o_reg_3;
   logic [REG_WIDTH-1:0]     o_reg_4;
   logic [REG_WIDTH-1:0]     o_reg_5;
   logic [REG_WIDTH-1:0]     o_reg_6;
   logic [REG_WIDTH-1:0]     o_reg_7;
   logic [REG_WIDTH-1:0]     o_reg_8;
   logic                     o_data_valid;
   logic                     o_frame_err;
   logic [ERR_CNT_WIDTH-1:0] o_err_count;

   modport master (
      output i_byte, i_byte_valid, i_byte_last,
      input  o_byte_ready,
      input  o_reg_0, o_reg_1, o_reg_2, o_reg_3, o_reg_4,
      input  o_reg_5, o_reg_6, o_reg_7, o_reg_8,
      input  o_data_valid, o_frame_err, o_err_count
   );

   modport slave (
      input  i_byte, i_byte_valid, i_byte_last,
      output o_byte_ready,
      output o_reg_0, o_reg_1, o_reg_2, o_reg_3, o_reg_4,
      output o_reg_5, o_reg_6, o_reg_7, o_reg_8,
      output o_data_valid, o_frame_err, o_err_count
   );
endinterface

// File: rtl/itch_msg_assembler.sv
// ITCH message assembler: packs a byte stream little-endian into nine 32-bit
// words, checks length (exactly 36 bytes) and message type ('A'/'D'/'E'),
// pulses o_data_valid one cycle after a good frame's last byte and drops
// malformed frames, counting them in a saturating error counter.
module itch_msg_assembler #(
   parameter int REG_WIDTH     = 32,
   parameter int NUM_REGS      = 9,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   itch_msg_assembler_if.slave  bus
);
   localparam int MSG_BYTES = NUM_REGS * REG_WIDTH / 8;
   localparam int IDX_W     = $clog2(MSG_BYTES);

   typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, EMIT} state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [REG_WIDTH-1:0]     regs_q [NUM_REGS];
   logic [REG_WIDTH-1:0]     regs_d [NUM_REGS];
   logic                     frame_err_q, frame_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
   logic                     byte_ready;
   logic                     accept;
   logic                     type_ok;
   logic                     at_last_pos;
   logic                     reject;

   // Error counter sticks at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + ERR_CNT_WIDTH'(1);
   endfunction

   assign byte_ready  = (state_q != EMIT);
   assign accept      = bus.i_byte_valid & byte_ready;
   assign type_ok     = (bus.i_byte == 8'h41) || (bus.i_byte == 8'h44) || (bus.i_byte == 8'h45);
   assign at_last_pos = (idx_q == IDX_W'(MSG_BYTES - 1));

   // Next-state, byte packing and frame rejection decision.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      regs_d  = regs_q;
      reject  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               for (int r = 0; r < NUM_REGS; r++) regs_d[r] = '0;
               regs_d[0][7:0] = bus.i_byte;
               if (type_ok && !bus.i_byte_last) begin
                  state_d = COLLECT;
                  idx_d   = IDX_W'(1);
               end else begin
                  // Bad type, or a good type that is already the last byte.
                  reject  = 1'b1;
                  state_d = bus.i_byte_last ? IDLE : DISCARD;
               end
            end
         end
         COLLECT: begin
            if (accept) begin
               regs_d[idx_q[IDX_W-1:2]][{idx_q[1:0], 3'b000} +: 8] = bus.i_byte;
               idx_d = idx_q + IDX_W'(1);
               if (at_last_pos) begin
                  if (bus.i_byte_last) begin
                     state_d = EMIT;
                  end else begin
                     reject  = 1'b1;
                     state_d = DISCARD;
                  end
               end else if (bus.i_byte_last) begin
                  reject  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DISCARD: begin
            if (accept && bus.i_byte_last) state_d = IDLE;
         end
         EMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      frame_err_d = reject;
      err_count_d = reject ? sat_inc(err_count_q) : err_count_q;
   end

   // State, packed message words and error reporting registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         frame_err_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         regs_q      <= regs_d;
         frame_err_q <= frame_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.o_byte_ready = byte_ready;
   assign bus.o_data_valid = (state_q == EMIT);
   assign bus.o_frame_err  = frame_err_q;
   assign bus.o_err_count  = err_count_q;
   assign bus.o_reg_0      = regs_q[0];
   assign bus.o_reg_1      = regs_q[1];
   assign bus.o_reg_2      = regs_q[2];
   assign bus.o_reg_3      = regs_q[3];
   assign bus.o_reg_4      = regs_q[4];
   assign bus.o_reg_5      = regs_q[5];
   assign bus.o_reg_6      = regs_q[6];
   assign bus.o_reg_7      = regs_q[7];
   assign bus.o_reg_8      = regs_q[8];
endmodule

// File: tb/tb_itch_msg_assembler.sv
// Testbench for itch_msg_assembler: randomized frames against a frame-level
// reference model; a second instance with a 2-bit error counter sees the same
// stream to exercise counter saturation.
module tb_itch_msg_assembler;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   itch_msg_assembler_if #(.REG_WIDTH(32), .ERR_CNT_WIDTH(16)) bus ();
   itch_msg_assembler_if #(.REG_WIDTH(32), .ERR_CNT_WIDTH(2))  bus2 ();

   itch_msg_assembler #(.REG_WIDTH(32), .NUM_REGS(9), .ERR_CNT_WIDTH(16)) dut (
      .i_clk(clk), .i_reset(rst), .bus(bus.slave));
   itch_msg_assembler #(.REG_WIDTH(32), .NUM_REGS(9), .ERR_CNT_WIDTH(2)) dut2 (
      .i_clk(clk), .i_reset(rst), .bus(bus2.slave));

   assign bus2.i_byte       = bus.i_byte;
   assign bus2.i_byte_valid = bus.i_byte_valid;
   assign bus2.i_byte_last  = bus.i_byte_last;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed events
   logic [287:0] got_msg[$];
   int           got_vcyc[$];
   int           got_ecyc[$];
   int           ready_low;
   bit           both_seen = 1'b0;

   // Expected events from the model
   logic [287:0] exp_msg[$];
   int           exp_vcyc[$];
   int           exp_ecyc[$];
   int           exp_err16;
   int           exp_err2;
   int           acc_cyc[$];

   function automatic logic [287:0] cur_msg();
      return {bus.o_reg_8, bus.o_reg_7, bus.o_reg_6, bus.o_reg_5, bus.o_reg_4,
              bus.o_reg_3, bus.o_reg_2, bus.o_reg_1, bus.o_reg_0};
   endfunction

   function automatic logic [287:0] cur_msg2();
      return {bus2.o_reg_8, bus2.o_reg_7, bus2.o_reg_6, bus2.o_reg_5, bus2.o_reg_4,
              bus2.o_reg_3, bus2.o_reg_2, bus2.o_reg_1, bus2.o_reg_0};
   endfunction

   always @(negedge clk) begin
      if (bus.o_data_valid === 1'b1) begin
         got_msg.push_back(cur_msg());
         got_vcyc.push_back(cyc);
      end
      if (bus.o_frame_err === 1'b1) got_ecyc.push_back(cyc);
      if (bus.o_byte_ready !== 1'b1) ready_low++;
      if (bus.o_data_valid === 1'b1 && bus.o_frame_err === 1'b1) both_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      got_msg.delete(); got_vcyc.delete(); got_ecyc.delete();
      exp_msg.delete(); exp_vcyc.delete(); exp_ecyc.delete();
      ready_low = 0;
   endtask

   function automatic bit is_good_type(input logic [7:0] t);
      return (t == 8'h41) || (t == 8'h44) || (t == 8'h45);
   endfunction

   function automatic bq_t mk_frame(input logic [7:0] typ, input int len);
      bq_t q;
      q.push_back(typ);
      for (int i = 1; i < len; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // Frame-level reference: a frame is delivered iff it is exactly 36 bytes
   // with a good type; otherwise it is rejected once, at byte 0 for a bad type,
   // at its last byte when short, or at byte 35 when long. Outputs appear in
   // the cycle following the one where the deciding byte was on the bus.
   task automatic model_frame(input bq_t fb);
      int n   = fb.size();
      int bad = -1;
      logic [287:0] m = '0;
      if (!is_good_type(fb[0])) bad = 0;
      else if (n < 36)          bad = n - 1;
      else if (n > 36)          bad = 35;
      if (bad >= 0) begin
         exp_ecyc.push_back(acc_cyc[bad]);
         if (exp_err16 < 65535) exp_err16++;
         if (exp_err2 < 3)      exp_err2++;
      end else begin
         for (int k = 0; k < 36; k++) m[8*k +: 8] = fb[k];
         exp_msg.push_back(m);
         exp_vcyc.push_back(acc_cyc[35]);
      end
   endtask

   // Drives one frame starting at posedge+1; gap_pct is the chance of an idle
   // cycle before each byte. Leaves i_byte_valid asserted for back-to-back use.
   task automatic send_frame(input bq_t fb, input int gap_pct);
      acc_cyc.delete();
      for (int i = 0; i < fb.size(); i++) begin
         int t = 0;
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.i_byte_valid = 1'b0;
            bus.i_byte_last  = 1'b0;
            @(posedge clk); #1;
         end
         bus.i_byte       = fb[i];
         bus.i_byte_valid = 1'b1;
         bus.i_byte_last  = (i == fb.size() - 1);
         while (bus.o_byte_ready !== 1'b1) begin
            @(posedge clk); #1;
            t++;
            if (t > 20) begin
               $display("FAIL ready_timeout: o_byte_ready stuck at %b, required 1", bus.o_byte_ready);
               $fatal(1, "ready timeout");
            end
         end
         @(posedge clk); #1;
         acc_cyc.push_back(cyc);
      end
      model_frame(fb);
   endtask

   task automatic idle(input int n);
      bus.i_byte_valid = 1'b0;
      bus.i_byte_last  = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_byte = 8'h00; bus.i_byte_valid = 1'b0; bus.i_byte_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.o_byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.o_byte_ready); end
      n_checks++; if (bus.o_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.o_data_valid); end
      n_checks++; if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b required 0", bus.o_frame_err); end
      n_checks++; if (bus.o_err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d required 0", bus.o_err_count); end
      n_checks++; if (cur_msg() !== 288'd0) begin n_fail++; $display("FAIL reset_regs: got %h required 0", cur_msg()); end
      n_checks++; if ({bus2.o_byte_ready, bus2.o_data_valid, bus2.o_frame_err, bus2.o_err_count} !== 5'b10000) begin
         n_fail++; $display("FAIL reset_dut2_ctrl: got %b required 10000", {bus2.o_byte_ready, bus2.o_data_valid, bus2.o_frame_err, bus2.o_err_count}); end
      rst = 1'b0;
      @(posedge clk); #1;
      exp_err16 = 0; exp_err2 = 0;
      clear_obs();
   endtask

   task automatic test_a_frame();
      bq_t fb;
      clear_obs();
      fb = mk_frame(8'h41, 36);
      fb[28] = 8'h4C; fb[29] = 8'h50; fb[30] = 8'h41; fb[31] = 8'h41;
      fb[32] = 8'h88; fb[33] = 8'h13; fb[34] = 8'h00; fb[35] = 8'h00;
      send_frame(fb, 0);
      idle(3);
      n_checks++; if (got_msg.size() !== 1) begin n_fail++; $display("FAIL a_valid_count: got %0d required 1", got_msg.size()); end
      if (got_msg.size() >= 1) begin
         n_checks++; if (got_vcyc[0] !== acc_cyc[35]) begin n_fail++; $display("FAIL a_latency: valid at cycle %0d required %0d", got_vcyc[0], acc_cyc[35]); end
         n_checks++; if (got_msg[0] !== exp_msg[0]) begin n_fail++; $display("FAIL a_message: got %h required %h", got_msg[0], exp_msg[0]); end
      end
      n_checks++; if (bus.o_reg_0[7:0] !== 8'h41) begin n_fail++; $display("FAIL a_reg0_type: got %h required 41", bus.o_reg_0[7:0]); end
      n_checks++; if (bus.o_reg_7 !== 32'h4141504C) begin n_fail++; $display("FAIL a_reg7: got %h required 4141504c", bus.o_reg_7); end
      n_checks++; if (bus.o_reg_8 !== 32'h00001388) begin n_fail++; $display("FAIL a_reg8: got %h required 00001388", bus.o_reg_8); end
      n_checks++; if (got_ecyc.size() !== 0) begin n_fail++; $display("FAIL a_no_err: got %0d error pulses required 0", got_ecyc.size()); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] types [3] = '{8'h44, 8'h45, 8'h41};
      clear_obs();
      for (int f = 0; f < 3; f++) send_frame(mk_frame(types[f], 36), 0);
      idle(3);
      n_checks++; if (ready_low !== 3) begin n_fail++; $display("FAIL b2b_ready_low: got %0d cycles required 3", ready_low); end
      n_checks++; if (got_msg.size() !== 3) begin n_fail++; $display("FAIL b2b_valid_count: got %0d required 3", got_msg.size()); end
      for (int i = 0; i < 3 && i < got_msg.size(); i++) begin
         n_checks++; if (got_msg[i] !== exp_msg[i]) begin n_fail++; $display("FAIL b2b_message%0d: got %h required %h", i, got_msg[i], exp_msg[i]); end
         n_checks++; if (got_vcyc[i] !== exp_vcyc[i]) begin n_fail++; $display("FAIL b2b_valid_cycle%0d: got %0d required %0d", i, got_vcyc[i], exp_vcyc[i]); end
         if (i > 0) begin
            n_checks++; if (got_vcyc[i] - got_vcyc[i-1] !== 37) begin n_fail++; $display("FAIL b2b_period%0d: got %0d required 37", i, got_vcyc[i] - got_vcyc[i-1]); end
         end
      end
   endtask

   // Bad type, short and long frames, each followed by a good frame.
   task automatic test_error_frames();
      logic [7:0] bad_t [3] = '{8'h58, 8'h44, 8'h41};
      int         bad_l [3] = '{36, 21, 40};
      logic [7:0] good_t[3] = '{8'h45, 8'h44, 8'h41};
      for (int s = 0; s < 3; s++) begin
         int e0 = int'(bus.o_err_count);
         clear_obs();
         send_frame(mk_frame(bad_t[s], bad_l[s]), 10);
         send_frame(mk_frame(good_t[s], 36), 10);
         idle(3);
         n_checks++; if (got_ecyc.size() !== 1) begin n_fail++; $display("FAIL err%0d_pulses: got %0d required 1", s, got_ecyc.size()); end
         if (got_ecyc.size() >= 1) begin
            n_checks++; if (got_ecyc[0] !== exp_ecyc[0]) begin n_fail++; $display("FAIL err%0d_cycle: got %0d required %0d", s, got_ecyc[0], exp_ecyc[0]); end
         end
         n_checks++; if (int'(bus.o_err_count) !== e0 + 1) begin n_fail++; $display("FAIL err%0d_count: got %0d required %0d", s, bus.o_err_count, e0 + 1); end
         n_checks++; if (got_msg.size() !== 1) begin n_fail++; $display("FAIL err%0d_valid_count: got %0d required 1", s, got_msg.size()); end
         if (got_msg.size() >= 1) begin
            n_checks++; if (got_msg[0] !== exp_msg[0]) begin n_fail++; $display("FAIL err%0d_follow_msg: got %h required %h", s, got_msg[0], exp_msg[0]); end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bq_t fb = mk_frame(8'h44, 36);
      for (int i = 0; i < 17; i++) begin
         bus.i_byte = fb[i]; bus.i_byte_valid = 1'b1; bus.i_byte_last = 1'b0;
         @(posedge clk); #1;
      end
      bus.i_byte = fb[17];
      #2 rst = 1'b1;
      #1;
      n_checks++; if (cur_msg() !== 288'd0) begin n_fail++; $display("FAIL midrst_regs: got %h required 0", cur_msg()); end
      n_checks++; if (bus.o_err_count !== 16'd0) begin n_fail++; $display("FAIL midrst_err_count: got %0d required 0", bus.o_err_count); end
      n_checks++; if (bus.o_byte_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", bus.o_byte_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_err16 = 0; exp_err2 = 0;
      idle(1);
      clear_obs();
      send_frame(mk_frame(8'h41, 36), 20);
      send_frame(mk_frame(8'h58, 1 + int'($urandom_range(39))), 20);
      send_frame(mk_frame(8'h41, 1 + int'($urandom_range(34))), 20);
      send_frame(mk_frame(8'h44, 37 + int'($urandom_range(3))), 20);
      send_frame(mk_frame(8'h00, 36), 20);
      send_frame(mk_frame(8'h45, 20), 20);
      idle(3);
      n_checks++; if (got_msg.size() !== 1) begin n_fail++; $display("FAIL midrst_valid_count: got %0d required 1", got_msg.size()); end
      if (got_msg.size() >= 1) begin
         n_checks++; if (got_msg[0] !== exp_msg[0]) begin n_fail++; $display("FAIL midrst_clean_msg: got %h required %h", got_msg[0], exp_msg[0]); end
      end
      n_checks++; if (got_ecyc.size() !== 5) begin n_fail++; $display("FAIL midrst_err_pulses: got %0d required 5", got_ecyc.size()); end
      n_checks++; if (bus.o_err_count !== 16'd5) begin n_fail++; $display("FAIL midrst_err_count: got %0d required 5", bus.o_err_count); end
      n_checks++; if (bus2.o_err_count !== 2'd3) begin n_fail++; $display("FAIL sat_err_count: got %0d required 3", bus2.o_err_count); end
   endtask

   task automatic test_random();
      clear_obs();
      for (int f = 0; f < 25; f++) begin
         int k = int'($urandom_range(4));
         logic [7:0] t;
         case (k)
            0, 1: begin
               t = (k == 0) ? 8'h44 : (($urandom_range(1) == 0) ? 8'h41 : 8'h45);
               send_frame(mk_frame(t, 36), 30);
            end
            2: begin
               t = 8'($urandom);
               while (is_good_type(t)) t = 8'($urandom);
               send_frame(mk_frame(t, 1 + int'($urandom_range(43))), 30);
            end
            3: send_frame(mk_frame(8'h45, 1 + int'($urandom_range(34))), 30);
            default: send_frame(mk_frame(8'h41, 37 + int'($urandom_range(7))), 30);
         endcase
         if ($urandom_range(1) == 0) idle(int'($urandom_range(2)));
      end
      idle(3);
      n_checks++; if (got_msg.size() !== exp_msg.size()) begin n_fail++; $display("FAIL rnd_valid_count: got %0d required %0d", got_msg.size(), exp_msg.size()); end
      for (int i = 0; i < got_msg.size() && i < exp_msg.size(); i++) begin
         n_checks++; if (got_msg[i] !== exp_msg[i] || got_vcyc[i] !== exp_vcyc[i]) begin
            n_fail++; $display("FAIL rnd_msg%0d: got %h at %0d required %h at %0d", i, got_msg[i], got_vcyc[i], exp_msg[i], exp_vcyc[i]); end
      end
      n_checks++; if (got_ecyc != exp_ecyc) begin n_fail++; $display("FAIL rnd_err_events: got %0d pulses required %0d", got_ecyc.size(), exp_ecyc.size()); end
      n_checks++; if (int'(bus.o_err_count) !== exp_err16) begin n_fail++; $display("FAIL rnd_err_count: got %0d required %0d", bus.o_err_count, exp_err16); end
      n_checks++; if (int'(bus2.o_err_count) !== exp_err2) begin n_fail++; $display("FAIL rnd_err_count_sat: got %0d required %0d", bus2.o_err_count, exp_err2); end
      n_checks++; if (cur_msg2() !== cur_msg()) begin n_fail++; $display("FAIL rnd_dut2_regs: got %h required %h", cur_msg2(), cur_msg()); end
      n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL valid_err_overlap: got %b required 0", both_seen); end
   endtask

   initial begin
      test_reset();
      test_a_frame();
      test_back_to_back();
      test_error_frames();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
